// File: rtl/echo_cancel_sequencer_if.sv
// echo_cancel_sequencer_if: start/done handshakes, data words and status between the sequencer and the echo-cancellation datapath
interface echo_cancel_sequencer_if #(parameter int CNT_W = 13, DW = 64, ITER_W = 16);
  logic enable;
  logic [CNT_W-1:0] sampling_cycle_counter;
  logic conv_tx_start, conv_tx_done, conv_rx_start, conv_rx_done;
  logic adapt_start, adapt_done, cancel_start, cancel_done;
  logic [DW-1:0] e_data, cancel_data, out_data;
  logic samp_en_cancel, samp_en_adapt, out_load, training, err_timeout, err_overrun;
  logic [ITER_W-1:0] iteration;
  modport master (
    input enable, sampling_cycle_counter, conv_tx_done, conv_rx_done, adapt_done, cancel_done, e_data, cancel_data,
    output conv_tx_start, conv_rx_start, adapt_start, cancel_start, samp_en_cancel, samp_en_adapt,
    output out_data, out_load, training, iteration, err_timeout, err_overrun
  );
  modport slave (
    output enable, sampling_cycle_counter, conv_tx_done, conv_rx_done, adapt_done, cancel_done, e_data, cancel_data,
    input conv_tx_start, conv_rx_start, adapt_start, cancel_start, samp_en_cancel, samp_en_adapt,
    input out_data, out_load, training, iteration, err_timeout, err_overrun
  );
endinterface

// File: rtl/echo_cancel_sequencer.sv
// echo_cancel_sequencer: per-sample tx/rx/adapt-or-cancel/out handshake sequencer with warm-up, timeout and overrun status (option CONTINUOUS_ADAPT_EN)
module echo_cancel_sequencer #(
  parameter int CNT_W = 13,
  parameter int DW = 64,
  parameter int WARMUP_A = 2,
  parameter int WARMUP_B = 4,
  parameter int TRAIN_ITERS = 100,
  parameter int ITER_W = 16,
  parameter int TIMEOUT_CYC = 4095
) (
  input logic clk_operation,
  input logic rst,
  echo_cancel_sequencer_if.master bus
);
  localparam int SW = $clog2(WARMUP_B + 2);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [2:0] {IDLE, TX, RX, ADAPT, CANCEL, OUT} state_t;
  state_t r_state, w_state_n;
  logic r_prev_zero;
  logic [SW-1:0] r_samp_cnt, w_samp_n;
  logic [TW-1:0] r_timer;
  logic w_tick, w_wait, w_done, w_timeout;
  logic w_tx_go, w_rx_go, w_adapt_go, w_cancel_go;
  assign w_tick = (bus.sampling_cycle_counter == '0) && !r_prev_zero;
  assign w_samp_n = (w_tick && r_samp_cnt != SW'(WARMUP_B)) ? r_samp_cnt + 1'b1 : r_samp_cnt;
  always_comb begin
    w_state_n = r_state;
    w_wait = 1'b0;
    w_done = 1'b0;
    w_tx_go = 1'b0;
    w_rx_go = 1'b0;
    w_adapt_go = 1'b0;
    w_cancel_go = 1'b0;
    case (r_state)
      IDLE: begin
        w_tx_go = w_tick && bus.enable;
        w_state_n = w_tx_go ? TX : IDLE;
      end
      TX: begin
        w_wait = 1'b1;
        w_done = bus.conv_tx_done;
        w_rx_go = w_done;
        w_state_n = w_done ? RX : TX;
      end
      RX: begin
        w_wait = 1'b1;
        w_done = bus.conv_rx_done;
        w_adapt_go = w_done && bus.training && bus.samp_en_adapt;
        w_cancel_go = w_done && !bus.training;
        w_state_n = w_adapt_go ? ADAPT : w_cancel_go ? CANCEL : w_done ? IDLE : RX;
      end
      ADAPT: begin
        w_wait = 1'b1;
        w_done = bus.adapt_done;
        w_state_n = w_done ? OUT : ADAPT;
      end
      CANCEL: begin
        w_wait = 1'b1;
        w_done = bus.cancel_done;
`ifdef CONTINUOUS_ADAPT_EN
        w_adapt_go = w_done;
        w_state_n = w_done ? ADAPT : CANCEL;
`else
        w_state_n = w_done ? OUT : CANCEL;
`endif
      end
      OUT: w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
    w_timeout = w_wait && !w_done && r_timer == TW'(TIMEOUT_CYC - 1);
    if (w_timeout) w_state_n = IDLE;
  end
  always_ff @(posedge clk_operation) begin
    if (rst) begin
      r_state <= IDLE;
      r_prev_zero <= 1'b0;
      r_samp_cnt <= '0;
      r_timer <= '0;
      bus.conv_tx_start <= 1'b0;
      bus.conv_rx_start <= 1'b0;
      bus.adapt_start <= 1'b0;
      bus.cancel_start <= 1'b0;
      bus.samp_en_cancel <= 1'b0;
      bus.samp_en_adapt <= 1'b0;
      bus.out_data <= '0;
      bus.out_load <= 1'b0;
      bus.training <= 1'b1;
      bus.iteration <= '0;
      bus.err_timeout <= 1'b0;
      bus.err_overrun <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_prev_zero <= bus.sampling_cycle_counter == '0;
      r_samp_cnt <= w_samp_n;
      r_timer <= (w_wait && w_state_n == r_state) ? r_timer + 1'b1 : '0;
      bus.samp_en_cancel <= w_samp_n >= SW'(WARMUP_A);
      bus.samp_en_adapt <= w_samp_n >= SW'(WARMUP_B);
      bus.conv_tx_start <= w_tx_go;
      bus.conv_rx_start <= w_rx_go;
      bus.adapt_start <= w_adapt_go;
      bus.cancel_start <= w_cancel_go;
      bus.out_load <= r_state == OUT;
      if (r_state == ADAPT && w_done) begin
        bus.iteration <= (&bus.iteration) ? bus.iteration : bus.iteration + 1'b1;
        // in run mode ADAPT only follows CANCEL, whose result is the output word
        if (bus.training) bus.out_data <= bus.e_data;
      end
      if (r_state == CANCEL && w_done) bus.out_data <= bus.cancel_data;
      if (r_state == OUT && bus.iteration == ITER_W'(TRAIN_ITERS)) bus.training <= 1'b0;
      if (w_timeout) bus.err_timeout <= 1'b1;
      if (w_tick && r_state != IDLE) bus.err_overrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_echo_cancel_sequencer.sv
// tb_echo_cancel_sequencer: directed scenarios with an out_data scoreboard and handshake responders
module tb_echo_cancel_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  int n_tx = 0, n_rx = 0, n_adapt = 0, n_cancel = 0, n_load = 0;
  int cd_tx = 0, cd_rx = 0, cd_adapt = 0, cd_cancel = 0;
  logic hold_adapt = 1'b0;
  int base_tx, base_load;
  echo_cancel_sequencer_if #(.CNT_W(13), .DW(64), .ITER_W(16)) bus ();
  echo_cancel_sequencer #(
    .CNT_W(13), .DW(64), .WARMUP_A(1), .WARMUP_B(2), .TRAIN_ITERS(3), .ITER_W(16), .TIMEOUT_CYC(16)
  ) dut (
    .clk_operation(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk) bus.sampling_cycle_counter = 13'd0;
    @(negedge clk) bus.sampling_cycle_counter = 13'd5;
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  always @(negedge clk) begin
    bus.conv_tx_done = 1'b0;
    bus.conv_rx_done = 1'b0;
    bus.adapt_done = 1'b0;
    bus.cancel_done = 1'b0;
    if (cd_tx > 0) begin cd_tx--; bus.conv_tx_done = cd_tx == 0; end
    if (cd_rx > 0) begin cd_rx--; bus.conv_rx_done = cd_rx == 0; end
    if (cd_adapt > 0) begin cd_adapt--; bus.adapt_done = cd_adapt == 0 && !hold_adapt; end
    if (cd_cancel > 0) begin cd_cancel--; bus.cancel_done = cd_cancel == 0; end
    if (bus.conv_tx_start) begin cd_tx = 5; n_tx++; end
    if (bus.conv_rx_start) begin cd_rx = 5; n_rx++; end
    if (bus.adapt_start) begin cd_adapt = 5; n_adapt++; end
    if (bus.cancel_start) begin cd_cancel = 5; n_cancel++; end
  end
  always @(negedge clk) begin
    if (bus.out_load) begin
      n_load++;
      if (exp_q.size() == 0) check("out_load_unexpected", 64'd1, 64'd0);
      else check("out_data", bus.out_data, exp_q.pop_front());
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.enable = 1'b0;
    bus.sampling_cycle_counter = 13'd5;
    bus.e_data = '0;
    bus.cancel_data = '0;
    idle(3);
    check("rst_training", bus.training, 1);
    check("rst_out_load", bus.out_load, 0);
    check("rst_iteration", bus.iteration, 0);
    check("rst_samp_en", {bus.samp_en_cancel, bus.samp_en_adapt}, 0);
    check("rst_err", {bus.err_timeout, bus.err_overrun}, 0);
    check("rst_starts", {bus.conv_tx_start, bus.conv_rx_start, bus.adapt_start, bus.cancel_start}, 0);
    rst = 1'b0;
    bus.enable = 1'b1;
    tick();
    check("tick1_samp_en_cancel", bus.samp_en_cancel, 1);
    check("tick1_samp_en_adapt", bus.samp_en_adapt, 0);
    idle(30);
    check("tick1_starts", {n_tx[7:0], n_rx[7:0], n_adapt[7:0], n_load[7:0]}, {8'd1, 8'd1, 8'd0, 8'd0});
    bus.enable = 1'b0;
    tick();
    check("tick2_samp_en_adapt", bus.samp_en_adapt, 1);
    idle(30);
    check("tick2_disabled_no_tx", n_tx, 1);
    bus.enable = 1'b1;
    bus.e_data = 64'h3FF0000000000000;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(64'h3FF0000000000000);
      tick();
      idle(30);
      if (i == 1) check("training_before_third", bus.training, 1);
    end
    check("train_iteration", bus.iteration, 3);
    check("train_training", bus.training, 0);
    check("train_counts", {n_adapt[7:0], n_load[7:0]}, {8'd3, 8'd3});
    bus.cancel_data = 64'h4000000000000000;
    exp_q.push_back(64'h4000000000000000);
    tick();
    idle(40);
    check("run_cancel_start", n_cancel, 1);
`ifdef CONTINUOUS_ADAPT_EN
    check("run_adapt_start", n_adapt, 4);
    check("run_iteration", bus.iteration, 4);
`else
    check("run_adapt_start", n_adapt, 3);
    check("run_iteration", bus.iteration, 3);
`endif
    check("run_load", n_load, 4);
    base_tx = n_tx;
    base_load = n_load;
    exp_q.push_back(64'h4000000000000000);
    tick();
    idle(6);
    tick();
    idle(40);
    check("overrun_flag", bus.err_overrun, 1);
    check("overrun_one_sample", n_tx - base_tx, 1);
    check("overrun_completes", n_load - base_load, 1);
    check("overrun_no_timeout", bus.err_timeout, 0);
    base_tx = n_tx;
    base_load = n_load;
    exp_q.push_back(64'h4000000000000000);
    @(negedge clk) bus.sampling_cycle_counter = 13'd0;
    idle(10);
    bus.sampling_cycle_counter = 13'd5;
    idle(40);
    check("held_zero_one_tick", n_tx - base_tx, 1);
    check("held_zero_one_load", n_load - base_load, 1);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    check("rst2_training", bus.training, 1);
    check("rst2_err", {bus.err_timeout, bus.err_overrun}, 0);
    bus.enable = 1'b0;
    tick();
    tick();
    idle(3);
    bus.enable = 1'b1;
    base_load = n_load;
    hold_adapt = 1'b1;
    tick();
    idle(20);
    check("timeout_not_early", bus.err_timeout, 0);
    idle(12);
    check("timeout_flag", bus.err_timeout, 1);
    check("timeout_no_load", n_load - base_load, 0);
    check("timeout_iteration", bus.iteration, 0);
    hold_adapt = 1'b0;
    idle(5);
    bus.e_data = 64'hC008000000000000;
    exp_q.push_back(64'hC008000000000000);
    tick();
    idle(30);
    check("after_timeout_iteration", bus.iteration, 1);
    check("after_timeout_load", n_load - base_load, 1);
    base_load = n_load;
    tick();
    idle(14);
    rst = 1'b1;
    idle(1);
    check("rst_adapt_training", bus.training, 1);
    check("rst_adapt_iteration", bus.iteration, 0);
    check("rst_adapt_outputs", {bus.out_load, bus.adapt_start, bus.err_timeout, bus.samp_en_adapt}, 0);
    rst = 1'b0;
    idle(30);
    check("late_done_no_load", n_load - base_load, 0);
    check("late_done_iteration", bus.iteration, 0);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
